// File: rtl/muldiv_hilo_ctrl_if.sv
// rtl/muldiv_hilo_ctrl_if.sv - request/response bundle between pipeline and mul/div HI/LO unit
// Ports (pipeline = master, unit = slave):
//   start/op/a/b      launch MULT/MULTU/DIV/DIVU/MTHI/MTLO
//   rd_hi/rd_lo       MFHI/MFLO request, rd_data returns the register
//   busy/stall        op in flight / pipeline must hold its request
//   done/div_by_zero  one-cycle completion pulses
//   hi/lo             architectural HI/LO
interface muldiv_hilo_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             rd_hi;
  logic             rd_lo;
  logic [WIDTH-1:0] rd_data;
  logic             busy;
  logic             stall;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, rd_hi, rd_lo,
    input  rd_data, busy, stall, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, rd_hi, rd_lo,
    output rd_data, busy, stall, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_hilo_ctrl.sv
// rtl/muldiv_hilo_ctrl.sv - iterative multiply/divide sequencer owning HI/LO
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      muldiv_hilo_ctrl_if.slave (start/op/a/b, rd_hi/rd_lo/rd_data,
//            busy/stall/done/div_by_zero, hi/lo)
module muldiv_hilo_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  muldiv_hilo_ctrl_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t             r_state;
  logic               r_is_div;
  logic               r_neg;      // quotient/product must be negated
  logic               r_rneg;     // remainder takes sign of dividend
  logic               r_dz;
  logic [WIDTH-1:0]   r_m;        // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] r_acc;      // MUL: {partial, multiplier}; DIV: {rem, dividend/quotient}
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  logic               r_dz_pulse;

  logic               w_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_trial;

  always_comb begin
    w_signed = ~bus.op[0];
    w_a_neg  = w_signed & bus.a[WIDTH-1];
    w_b_neg  = w_signed & bus.b[WIDTH-1];
    w_a_mag  = w_a_neg ? -bus.a : bus.a;
    w_b_mag  = w_b_neg ? -bus.b : bus.b;
    // Shift-add step: add multiplicand into the upper half when the current
    // multiplier bit is set; the carry becomes the new top bit after the shift.
    w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_m} : '0);
    // Restoring step: shift in the next dividend bit and try subtracting.
    w_trial  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]} - {1'b0, r_m};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_is_div   <= 1'b0;
      r_neg      <= 1'b0;
      r_rneg     <= 1'b0;
      r_dz       <= 1'b0;
      r_m        <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_dz_pulse <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_dz_pulse <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start && !bus.op[2]) begin
            r_is_div <= bus.op[1];
            r_neg    <= w_a_neg ^ w_b_neg;
            r_rneg   <= w_a_neg;
            r_dz     <= bus.op[1] && (bus.b == '0);
            r_cnt    <= '0;
            if (bus.op[1]) begin
              r_m     <= w_b_mag;
              r_acc   <= {{WIDTH{1'b0}}, w_a_mag};
              r_state <= S_DIV;
            end else begin
              r_m     <= w_a_mag;
              r_acc   <= {{WIDTH{1'b0}}, w_b_mag};
              r_state <= S_MUL;
            end
          end else if (bus.start && bus.op == 3'b100) begin
            r_hi <= bus.a;
          end else if (bus.start && bus.op == 3'b101) begin
            r_lo <= bus.a;
          end
        end
        S_MUL: begin
          r_acc <= {w_sum, r_acc[WIDTH-1:1]};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) r_state <= S_FIX;
        end
        S_DIV: begin
          if (w_trial[WIDTH]) r_acc <= {r_acc[2*WIDTH-2:0], 1'b0};
          else                r_acc <= {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) r_state <= S_FIX;
        end
        S_FIX: begin
          if (r_is_div) begin
            // Divide by zero leaves the remainder equal to |a|; restoring its
            // sign yields the original a in HI.
            r_lo       <= r_dz ? '1 : (r_neg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
            r_hi       <= r_rneg ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
            r_dz_pulse <= r_dz;
          end else begin
            {r_hi, r_lo} <= r_neg ? -r_acc : r_acc;
          end
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = (r_state != S_IDLE);
  assign bus.stall       = bus.busy & (bus.start | bus.rd_hi | bus.rd_lo);
  assign bus.rd_data     = bus.rd_hi ? r_hi : r_lo;
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dz_pulse;
  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;
endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// tb/tb_muldiv_hilo_ctrl.sv - scoreboard bench for muldiv_hilo_ctrl
module tb_muldiv_hilo_ctrl;
  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_NOP   = 3'b110;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  int   busy_cnt;
  logic prev_done;
  exp_t sb_q[$];

  muldiv_hilo_ctrl_if #(.WIDTH(32)) bus ();

  muldiv_hilo_ctrl #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
    exp_t e;
    e.hi = ehi;
    e.lo = elo;
    e.dz = edz;
    sb_q.push_back(e);
  endtask

  task automatic launch(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = av;
    bus.b     = bv;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!bus.done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_timeout", {63'd0, bus.done}, 64'd1);
  endtask

  task automatic run(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                     input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
    push_exp(ehi, elo, edz);
    launch(o, av, bv);
    wait_done();
  endtask

  // Monitor: pops the scoreboard on every done pulse.
  initial begin
    exp_t e;
    busy_cnt  = 0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        busy_cnt  = 0;
        prev_done = 1'b0;
      end else begin
        if (bus.busy) busy_cnt++;
        if (bus.div_by_zero && !bus.done) chk("dz_without_done", 64'd1, 64'd0);
        if (bus.done) begin
          chk("done_one_cycle", {63'd0, prev_done}, 64'd0);
          chk("busy_cycles", 64'(busy_cnt), 64'd33);
          busy_cnt = 0;
          if (sb_q.size() == 0) begin
            chk("unexpected_done", 64'd1, 64'd0);
          end else begin
            e = sb_q.pop_front();
            chk("hi", {32'd0, bus.hi}, {32'd0, e.hi});
            chk("lo", {32'd0, bus.lo}, {32'd0, e.lo});
            chk("div_by_zero", {63'd0, bus.div_by_zero}, {63'd0, e.dz});
          end
        end
        prev_done = bus.done;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks    = 0;
    errors    = 0;
    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.a     = '0;
    bus.b     = '0;
    bus.rd_hi = 1'b0;
    bus.rd_lo = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_done", {63'd0, bus.done}, 64'd0);
    chk("rst_hi", {32'd0, bus.hi}, 64'd0);
    chk("rst_lo", {32'd0, bus.lo}, 64'd0);
    bus.rd_hi = 1'b1;
    #1 chk("idle_stall", {63'd0, bus.stall}, 64'd0);
    bus.rd_hi = 1'b0;

    // Multiply
    run(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run(OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run(OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);

    // Divide
    run(OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run(OP_DIVU,  32'd7,         32'd2,         32'd1,         32'd3,         1'b0);
    run(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0);
    run(OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0);
    run(OP_DIV,   32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1);
    run(OP_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);

    // Stall: start and rd_lo held while busy must not recapture
    push_exp(32'h0000_0001, 32'h0002_0001, 1'b0);
    launch(OP_MULTU, 32'h0001_0001, 32'h0001_0001);
    bus.start = 1'b1;
    bus.op    = OP_MULTU;
    bus.a     = 32'd100;
    bus.b     = 32'd100;
    bus.rd_lo = 1'b1;
    for (int i = 0; i < 20; i++) begin
      chk("stall_held", {62'd0, bus.stall, bus.busy}, 64'd3);
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    bus.rd_lo = 1'b0;
    #1 chk("stall_released", {62'd0, bus.stall, bus.busy}, 64'd1);
    wait_done();
    @(posedge clk); #1;
    chk("no_recapture", {63'd0, bus.busy}, 64'd0);

    // MTHI then MFHI
    bus.start = 1'b1;
    bus.op    = OP_MTHI;
    bus.a     = 32'h0000_1234;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("mthi_busy", {63'd0, bus.busy}, 64'd0);
    bus.rd_hi = 1'b1;
    #1 chk("mfhi", {32'd0, bus.rd_data}, 64'h1234);
    bus.rd_hi = 1'b0;

    // MTLO and MFLO in one cycle returns the old LO
    bus.start = 1'b1;
    bus.op    = OP_MTLO;
    bus.a     = 32'h0000_0055;
    bus.rd_lo = 1'b1;
    #1 chk("mflo_old", {32'd0, bus.rd_data}, 64'h0002_0001);
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("mflo_new", {32'd0, bus.rd_data}, 64'h55);
    bus.rd_hi = 1'b1;
    #1 chk("rd_hi_wins", {32'd0, bus.rd_data}, 64'h1234);
    bus.rd_hi = 1'b0;
    bus.rd_lo = 1'b0;

    // Op code 11x ignored
    bus.start = 1'b1;
    bus.op    = OP_NOP;
    bus.a     = 32'h0000_AAAA;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("nop_busy", {63'd0, bus.busy}, 64'd0);
    chk("nop_hilo", {bus.hi, bus.lo}, {32'h0000_1234, 32'h0000_0055});

    // Asynchronous reset mid-divide
    launch(OP_DIV, 32'd100, 32'd7);
    repeat (10) begin
      @(posedge clk); #1;
    end
    #2 reset_n = 1'b0;
    #1;
    chk("arst_busy", {63'd0, bus.busy}, 64'd0);
    chk("arst_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("arst_done", {63'd0, bus.done}, 64'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle", {63'd0, bus.busy}, 64'd0);
    run(OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);

    repeat (3) @(posedge clk);
    #1 chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
